// File: rtl/posit_pkg.sv
// Shared constants and field bundle for the posit unpack/pack converter.
// The field struct carries the regime value, exponent and aligned fraction of a posit.
package posit_pkg;

   localparam int unsigned POSIT_BITS      = 32;
   localparam int unsigned POSIT_ES        = 3;
   localparam int unsigned POSIT_REG_LIMIT = POSIT_BITS - 2;

   typedef struct packed {
      logic [POSIT_BITS-1:0] seed;
      logic [POSIT_ES-1:0]   exp;
      logic [POSIT_BITS-1:0] frac;
   } posit_fields_t;

   // Largest regime magnitude a posit of the given width can encode.
   function automatic int unsigned reg_limit(input int unsigned bits);
      return bits - 2;
   endfunction

endpackage

// File: rtl/posit_codec_lzd.sv
// Leading run detector: length of the run of bits equal to the MSB, scanning downward.
// An all-identical word reports the full width W.
module posit_regime_lzd #(
   parameter int unsigned W = 31
) (
   input  logic [W-1:0]             bits,
   output logic [$clog2(W+1)-1:0]   run_len_c,
   output logic                     lead_c
);

   localparam int unsigned CW = $clog2(W + 1);

   logic found;

   assign lead_c = bits[W-1];

   always_comb begin
      run_len_c = CW'(W);
      found     = 1'b0;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         if (!found && (bits[i] != bits[W-1])) begin
            run_len_c = CW'(int'(W) - 1 - i);
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/posit_codec.sv
// Registered posit converter: unpack splits a posit into regime/exponent/fraction,
// pack rebuilds a posit from those fields with saturation. Both paths are independent.
module posit_codec
   import posit_pkg::*;
#(
   parameter int unsigned BITS = POSIT_BITS,
   parameter int unsigned ES   = POSIT_ES
) (
   input  logic            clk,
   input  logic            rst,

   input  logic            unpack_valid_in,
   input  logic [BITS-1:0] unpack_data,
   output logic            unpack_valid_out,
   output logic [BITS-1:0] unpack_seed,
   output logic [ES-1:0]   unpack_exp,
   output logic [BITS-1:0] unpack_frac,
   output logic            unpack_zero,
   output logic            unpack_nar,

   input  logic            pack_valid_in,
   input  logic [BITS-1:0] pack_seed,
   input  logic [ES-1:0]   pack_exp,
   input  logic [BITS-1:0] pack_frac,
   output logic            pack_valid_out,
   output logic [BITS-1:0] pack_posit
);

   localparam int unsigned REG_LIM = reg_limit(BITS);
   localparam int unsigned LW      = $clog2(BITS);
   localparam int unsigned SW      = LW + 1;
   localparam int unsigned PW      = 1 + ES + BITS;

   localparam logic signed [BITS-1:0] K_MAX = BITS'(REG_LIM);
   localparam logic signed [BITS-1:0] K_MIN = -K_MAX;

   // ---------------- unpack datapath ----------------
   logic [LW-1:0]   run_len;
   logic            lead;
   logic [SW-1:0]   un_shift;
   logic [BITS-1:0] un_rest;
   logic [BITS-1:0] un_seed;
   logic [ES-1:0]   un_exp;
   logic [BITS-1:0] un_frac;
   logic            un_zero;
   logic            un_nar;

   posit_regime_lzd #(
      .W (BITS - 1)
   ) u_lzd (
      .bits      (unpack_data[BITS-2:0]),
      .run_len_c (run_len),
      .lead_c    (lead)
   );

   // An all-zero body falls out naturally as a zero-run of BITS-1, i.e. k = -(BITS-1).
   always_comb begin
      un_shift = SW'(run_len) + SW'(1);
      un_rest  = {unpack_data[BITS-2:0], 1'b0} << un_shift;
      un_exp   = un_rest[BITS-1 -: ES];
      un_frac  = un_rest << ES;
      un_seed  = lead ? (BITS'(run_len) - BITS'(1)) : (BITS'(0) - BITS'(run_len));
      un_zero  = (unpack_data == '0);
      un_nar   = (unpack_data == {1'b1, {(BITS-1){1'b0}}});
   end

   // ---------------- pack datapath ----------------
   logic            pk_pos;
   logic [SW-1:0]   pk_run;
   logic [PW-1:0]   pk_tail;
   logic [PW-1:0]   pk_shifted;
   logic [BITS-2:0] pk_body;
   logic [BITS-1:0] pk_posit;

   // The terminator sits at the head of the tail; the regime is shifted in above it.
   always_comb begin
      pk_pos     = ~pack_seed[BITS-1];
      pk_run     = pk_pos ? SW'(pack_seed + BITS'(1)) : SW'(BITS'(0) - pack_seed);
      pk_tail    = {~pk_pos, pack_exp, pack_frac};
      pk_shifted = pk_pos ? ~((~pk_tail) >> pk_run) : (pk_tail >> pk_run);
      pk_body    = (BITS-1)'(pk_shifted >> (ES + 2));
      pk_posit   = {1'b0, pk_body};
      if ($signed(pack_seed) > K_MAX) begin
         pk_posit = {1'b0, {(BITS-1){1'b1}}};
      end else if ($signed(pack_seed) < K_MIN) begin
         pk_posit = BITS'(1);
      end
   end

   // ---------------- output registers ----------------
   logic            unpack_valid_q, unpack_valid_d;
   logic [BITS-1:0] unpack_seed_q,  unpack_seed_d;
   logic [ES-1:0]   unpack_exp_q,   unpack_exp_d;
   logic [BITS-1:0] unpack_frac_q,  unpack_frac_d;
   logic            unpack_zero_q,  unpack_zero_d;
   logic            unpack_nar_q,   unpack_nar_d;
   logic            pack_valid_q,   pack_valid_d;
   logic [BITS-1:0] pack_posit_q,   pack_posit_d;

   always_comb begin
      unpack_valid_d = unpack_valid_in;
      unpack_seed_d  = unpack_seed_q;
      unpack_exp_d   = unpack_exp_q;
      unpack_frac_d  = unpack_frac_q;
      unpack_zero_d  = unpack_zero_q;
      unpack_nar_d   = unpack_nar_q;
      pack_valid_d   = pack_valid_in;
      pack_posit_d   = pack_posit_q;
      if (unpack_valid_in) begin
         unpack_seed_d = un_seed;
         unpack_exp_d  = un_exp;
         unpack_frac_d = un_frac;
         unpack_zero_d = un_zero;
         unpack_nar_d  = un_nar;
      end
      if (pack_valid_in) begin
         pack_posit_d = pk_posit;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unpack_valid_q <= 1'b0;
         unpack_seed_q  <= '0;
         unpack_exp_q   <= '0;
         unpack_frac_q  <= '0;
         unpack_zero_q  <= 1'b0;
         unpack_nar_q   <= 1'b0;
         pack_valid_q   <= 1'b0;
         pack_posit_q   <= '0;
      end else begin
         unpack_valid_q <= unpack_valid_d;
         unpack_seed_q  <= unpack_seed_d;
         unpack_exp_q   <= unpack_exp_d;
         unpack_frac_q  <= unpack_frac_d;
         unpack_zero_q  <= unpack_zero_d;
         unpack_nar_q   <= unpack_nar_d;
         pack_valid_q   <= pack_valid_d;
         pack_posit_q   <= pack_posit_d;
      end
   end

   assign unpack_valid_out = unpack_valid_q;
   assign unpack_seed      = unpack_seed_q;
   assign unpack_exp       = unpack_exp_q;
   assign unpack_frac      = unpack_frac_q;
   assign unpack_zero      = unpack_zero_q;
   assign unpack_nar       = unpack_nar_q;
   assign pack_valid_out   = pack_valid_q;
   assign pack_posit       = pack_posit_q;

endmodule

// File: tb/tb_posit_codec.sv
// Scoreboard bench for posit_codec: directed vectors, async reset, and a
// randomised unpack->pack round trip with hold checks on idle cycles.
module tb_posit_codec;
   import posit_pkg::*;

   localparam int unsigned BITS = POSIT_BITS;
   localparam int unsigned ES   = POSIT_ES;
   localparam int          RT_N = 10000;
   localparam int          RT_BUDGET = 60000;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            unpack_valid_in = 1'b0;
   logic [BITS-1:0] unpack_data = '0;
   logic            unpack_valid_out;
   logic [BITS-1:0] unpack_seed;
   logic [ES-1:0]   unpack_exp;
   logic [BITS-1:0] unpack_frac;
   logic            unpack_zero;
   logic            unpack_nar;
   logic            pack_valid_in = 1'b0;
   logic [BITS-1:0] pack_seed = '0;
   logic [ES-1:0]   pack_exp = '0;
   logic [BITS-1:0] pack_frac = '0;
   logic            pack_valid_out;
   logic [BITS-1:0] pack_posit;

   posit_codec #(.BITS(BITS), .ES(ES)) dut (
      .clk              (clk),
      .rst              (rst),
      .unpack_valid_in  (unpack_valid_in),
      .unpack_data      (unpack_data),
      .unpack_valid_out (unpack_valid_out),
      .unpack_seed      (unpack_seed),
      .unpack_exp       (unpack_exp),
      .unpack_frac      (unpack_frac),
      .unpack_zero      (unpack_zero),
      .unpack_nar       (unpack_nar),
      .pack_valid_in    (pack_valid_in),
      .pack_seed        (pack_seed),
      .pack_exp         (pack_exp),
      .pack_frac        (pack_frac),
      .pack_valid_out   (pack_valid_out),
      .pack_posit       (pack_posit)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      posit_fields_t f;
      logic          zero;
      logic          nar;
   } unpack_exp_t;

   typedef struct {
      posit_fields_t f;
      logic [BITS-1:0] p;
   } fwd_t;

   unpack_exp_t     uq[$];
   logic [BITS-1:0] pq[$];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Reference decoder written as a plain bit scan.
   function automatic unpack_exp_t model_unpack(input logic [BITS-1:0] p);
      unpack_exp_t r;
      int   pos;
      int   m;
      logic ld;
      ld  = p[BITS-2];
      m   = 0;
      pos = int'(BITS) - 2;
      while (pos >= 0) begin
         if (p[pos] != ld) break;
         m++;
         pos--;
      end
      r.f.seed = ld ? BITS'(m - 1) : BITS'(-m);
      pos--;
      r.f.exp = '0;
      for (int j = int'(ES) - 1; j >= 0; j--) begin
         if (pos >= 0) r.f.exp[j] = p[pos];
         pos--;
      end
      r.f.frac = '0;
      for (int j = int'(BITS) - 1; j >= 0; j--) begin
         if (pos >= 0) r.f.frac[j] = p[pos];
         pos--;
      end
      r.zero = (p == '0);
      r.nar  = (p == {1'b1, {(BITS-1){1'b0}}});
      return r;
   endfunction

   // Monitor: pop on valid, check hold when idle.
   unpack_exp_t     mon_ue;
   logic [BITS-1:0] mon_pe;
   logic [BITS-1:0] prev_seed, prev_frac, prev_posit;
   logic [ES-1:0]   prev_exp;
   logic            prev_zero, prev_nar;

   always @(negedge clk) begin
      if (rst) begin
         prev_seed = '0; prev_frac = '0; prev_posit = '0;
         prev_exp = '0; prev_zero = 1'b0; prev_nar = 1'b0;
      end else begin
         if (unpack_valid_out) begin
            if (uq.size() == 0) begin
               check("unpack_unexpected_valid", 64'(unpack_valid_out), 64'(0));
            end else begin
               mon_ue = uq.pop_front();
               check("unpack_seed", 64'(unpack_seed), 64'(mon_ue.f.seed));
               check("unpack_exp",  64'(unpack_exp),  64'(mon_ue.f.exp));
               check("unpack_frac", 64'(unpack_frac), 64'(mon_ue.f.frac));
               check("unpack_zero", 64'(unpack_zero), 64'(mon_ue.zero));
               check("unpack_nar",  64'(unpack_nar),  64'(mon_ue.nar));
            end
         end else begin
            check("unpack_hold_seed_frac", {unpack_seed, unpack_frac}, {prev_seed, prev_frac});
            check("unpack_hold_flags", 64'({unpack_exp, unpack_zero, unpack_nar}),
                  64'({prev_exp, prev_zero, prev_nar}));
         end
         if (pack_valid_out) begin
            if (pq.size() == 0) begin
               check("pack_unexpected_valid", 64'(pack_valid_out), 64'(0));
            end else begin
               mon_pe = pq.pop_front();
               check("pack_posit", 64'(pack_posit), 64'(mon_pe));
            end
         end else begin
            check("pack_hold", 64'(pack_posit), 64'(prev_posit));
         end
         prev_seed = unpack_seed; prev_frac = unpack_frac; prev_exp = unpack_exp;
         prev_zero = unpack_zero; prev_nar = unpack_nar; prev_posit = pack_posit;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      unpack_valid_in = 1'b0;
      pack_valid_in   = 1'b0;
   endtask

   task automatic put_unpack(input logic [BITS-1:0] d, input logic [BITS-1:0] seed,
                             input logic [ES-1:0] e, input logic [BITS-1:0] frac,
                             input logic z, input logic n);
      unpack_exp_t x;
      x.f.seed = seed; x.f.exp = e; x.f.frac = frac; x.zero = z; x.nar = n;
      uq.push_back(x);
      unpack_valid_in = 1'b1;
      unpack_data     = d;
   endtask

   task automatic put_pack(input logic [BITS-1:0] seed, input logic [ES-1:0] e,
                           input logic [BITS-1:0] frac, input logic [BITS-1:0] expect_p);
      pq.push_back(expect_p);
      pack_valid_in = 1'b1;
      pack_seed     = seed;
      pack_exp      = e;
      pack_frac     = frac;
   endtask

   fwd_t            fwd[$];
   logic [BITS-1:0] pend[$];
   fwd_t            t;
   logic [BITS-1:0] rnd, p;
   int              issued, cyc;

   initial begin
      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_unpack_valid", 64'(unpack_valid_out), 64'(0));
      check("rst_pack_valid",   64'(pack_valid_out),   64'(0));
      check("rst_unpack_data",  {unpack_seed, unpack_frac}, 64'(0));
      check("rst_pack_posit",   64'(pack_posit), 64'(0));
      rst = 1'b0;
      tick();

      // Asynchronous reset while a result is being presented
      unpack_valid_in = 1'b1; unpack_data = 32'h48000000;
      pack_valid_in   = 1'b1; pack_seed = 32'd1; pack_exp = 3'd5; pack_frac = 32'h80000000;
      tick();
      #2 rst = 1'b1;
      #1;
      check("async_rst_unpack_valid", 64'(unpack_valid_out), 64'(0));
      check("async_rst_pack_valid",   64'(pack_valid_out),   64'(0));
      check("async_rst_unpack_exp",   64'(unpack_exp), 64'(0));
      check("async_rst_pack_posit",   64'(pack_posit), 64'(0));
      tick();
      tick();
      idle();
      rst = 1'b0;
      tick();
      check("post_rst_no_stale_unpack", 64'(unpack_valid_out), 64'(0));
      check("post_rst_no_stale_pack",   64'(pack_valid_out),   64'(0));

      // Directed unpacks
      put_unpack(32'h40000000, 32'h00000000, 3'd0, 32'h00000000, 1'b0, 1'b0); tick();
      put_unpack(32'h48000000, 32'h00000000, 3'd2, 32'h00000000, 1'b0, 1'b0); tick();
      put_unpack(32'h40400000, 32'h00000000, 3'd0, 32'h10000000, 1'b0, 1'b0); tick();
      put_unpack(32'h20000000, 32'hFFFFFFFF, 3'd0, 32'h00000000, 1'b0, 1'b0); tick();
      put_unpack(32'h7FFFFFFF, 32'd30,       3'd0, 32'h00000000, 1'b0, 1'b0); tick();
      put_unpack(32'h00000001, 32'hFFFFFFE2, 3'd0, 32'h00000000, 1'b0, 1'b0); tick();
      put_unpack(32'h00000000, 32'hFFFFFFE1, 3'd0, 32'h00000000, 1'b1, 1'b0); tick();
      put_unpack(32'h80000000, 32'hFFFFFFE1, 3'd0, 32'h00000000, 1'b0, 1'b1); tick();

      // Both paths in the same cycle
      put_unpack(32'h6B000000, 32'd1, 3'd5, 32'h80000000, 1'b0, 1'b0);
      put_pack(32'd1, 3'd5, 32'h80000000, 32'h6B000000); tick();
      put_unpack(32'h40000000, 32'd0, 3'd0, 32'h00000000, 1'b0, 1'b0);
      put_pack(32'd0, 3'd0, 32'h00000000, 32'h40000000); tick();
      unpack_valid_in = 1'b0;

      // Pack boundaries and saturation
      put_pack(32'd31,       3'd0, 32'h00000000, 32'h7FFFFFFF); tick();
      put_pack(32'hFFFFFFE1, 3'd0, 32'h00000000, 32'h00000001); tick();
      put_pack(32'd29,       3'd7, 32'h00000000, 32'h7FFFFFFE); tick();
      put_pack(32'hFFFFFFE2, 3'd7, 32'hFFFFFFFF, 32'h00000001); tick();
      put_pack(32'd30,       3'd7, 32'hFFFFFFFF, 32'h7FFFFFFF); tick();
      put_pack(32'hFFFFFFFF, 3'd0, 32'h00000000, 32'h20000000); tick();
      put_pack(32'h7FFFFFFF, 3'd0, 32'h00000000, 32'h7FFFFFFF); tick();
      put_pack(32'h80000000, 3'd0, 32'h00000000, 32'h00000001); tick();
      idle();
      repeat (3) tick();

      // Random round trip: unpack, forward fields at random, pack back
      issued = 0;
      cyc    = 0;
      while ((issued < RT_N || pend.size() != 0 || fwd.size() != 0) && cyc < RT_BUDGET) begin
         if (unpack_valid_out && pend.size() != 0) begin
            t.f.seed = unpack_seed; t.f.exp = unpack_exp; t.f.frac = unpack_frac;
            t.p = pend.pop_front();
            fwd.push_back(t);
         end
         pack_valid_in = 1'b0;
         if (fwd.size() != 0 && $urandom_range(3) != 0) begin
            t = fwd.pop_front();
            put_pack(t.f.seed, t.f.exp, t.f.frac, t.p);
         end else begin
            pack_seed = $urandom(); pack_frac = $urandom();
         end
         unpack_valid_in = 1'b0;
         rnd = $urandom();
         if (issued < RT_N && $urandom_range(1) == 1) begin
            p = {1'b0, rnd[BITS-2:0]};
            if (p == '0) p = BITS'(1);
            uq.push_back(model_unpack(p));
            pend.push_back(p);
            unpack_valid_in = 1'b1;
            unpack_data     = p;
            issued++;
         end else begin
            unpack_data = rnd;
         end
         tick();
         cyc++;
      end
      idle();
      check("roundtrip_drained", 64'(pend.size() + fwd.size()), 64'(0));
      repeat (3) tick();
      check("unpack_queue_empty", 64'(uq.size()), 64'(0));
      check("pack_queue_empty",   64'(pq.size()), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
